uart_rx_deserializer: RTL and testbench
=======================================

# uart_rx_deserializer

UART receive path: recovers serial frames from the asynchronous line `i_rx_in` using a fixed oversampling clock enable per bit. Each bit is sampled three times around mid-bit and resolved by majority vote. The block deserializes the bits LSB-first into a parallel word, optionally checks parity, checks the stop bit, and reports a one-cycle valid or error pulse per frame. It mirrors the transmit serializer and sits between the pad-side RX line and the receive FIFO/host logic.

## Interface
- `DATA_WIDTH`, 8: payload bits per frame (5–9).
- `OVERSAMPLE`, 8: clock cycles per bit; even, ≥ 8.
- `i_clk` input 1: clock; all logic is on the rising edge.
- `i_rst` input 1: one clock; reset is synchronous and active-high.
- `i_rx_in` input 1: asynchronous serial line; idles high.
- `i_parity_enable` input 1: when 1, a parity bit follows the data; sampled at frame start.
- `i_parity_type` input 1: 0 = even, 1 = odd; sampled at frame start.
- `o_data` output DATA_WIDTH: last received word; updated only on a good frame.
- `o_data_valid` output 1: one-cycle pulse when a frame completes with no error.
- `o_parity_error` output 1: one-cycle pulse at frame end when parity mismatches.
- `o_stop_error` output 1: one-cycle pulse at frame end when the stop bit is sampled as 0.
- `o_busy` output 1: high from the start-bit detection cycle through the frame-end cycle.

## Operation
- `i_rx_in` passes through a 2-flop synchronizer. The synchronizer flops reset to 1.
- Counters:
  - `edge_cnt` runs 0..OVERSAMPLE-1 within each bit.
  - `bit_cnt` runs 0..DATA_WIDTH-1 in the DATA state.
- Majority vote: samples are taken at `edge_cnt` = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is 1 if at least 2 samples are 1, and is latched after the third sample.
- Bit decisions act at `edge_cnt` = OVERSAMPLE-1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - **IDLE:** a synchronized 0 moves to START with `edge_cnt` = 0 in that same cycle. That cycle counts as the first cycle of the start bit. Parity config is latched here.
  - **START:** at the decision point, a voted 0 goes to DATA. A voted 1 is a glitch: return to IDLE with no pulse and no error.
  - **DATA:** at each decision, shift the voted bit into the shift register at the MSB and shift right (LSB arrives first). After bit DATA_WIDTH-1, go to PARITY if enabled, otherwise STOP.
  - **PARITY:** compute the expected value as XOR of the data bits XOR `i_parity_type`, and compare it with the voted bit. Hold the mismatch flag, then go to STOP.
  - **STOP:** at the decision point, raise the frame-end pulses and return to IDLE.
- Frame-end outputs:
  - Either error present → assert the relevant error pulse(s); `o_data` keeps its old value; no valid pulse.
  - No error → `o_data` ← shift register and `o_data_valid` = 1.
- A line already low on the return to IDLE (back-to-back frames) starts the next frame one cycle later.
- Reset mid-frame:
  - FSM → IDLE; counters → 0.
  - `o_data` → 0; all pulses and `o_busy` → 0.
  - The partial frame is discarded.

## Timing
- Reset values: `o_data` = 0, `o_data_valid` = 0, `o_parity_error` = 0, `o_stop_error` = 0, `o_busy` = 0.
- Line-to-FSM latency: 2 cycles (synchronizer).
- Frame duration: N = 1 + DATA_WIDTH + P + 1 bits, where P = 1 if parity is enabled, else 0.
- Frame-end pulses are registered and appear on the cycle after the STOP decision, i.e. N·OVERSAMPLE cycles after IDLE detects the synchronized 0.
- `o_busy` deasserts in that same cycle.
- All pulses are exactly one cycle wide. `o_data_valid` never coincides with an error pulse. `o_parity_error` and `o_stop_error` may coincide.
- Parity inputs changing mid-frame have no effect on that frame.

## Structure
- Package `uart_pkg`:
  - FSM state enum (`RX_IDLE`, `RX_START`, `RX_DATA`, `RX_PARITY`, `RX_STOP`).
  - Parity-type constants `PARITY_EVEN` = 0 and `PARITY_ODD` = 1, shared with the TX side.
- Sub-module `uart_rx_sampler`:
  - Contains the 2-flop synchronizer plus the 3-sample majority voter.
  - Inputs: `edge_cnt` and the raw line. Outputs: synchronized line and voted bit.
- FSM, counters, shift register and parity check live in the top module.

## Test plan
- OVERSAMPLE = 8, no parity, line sends 0xA5 with a good stop bit → `o_data_valid` pulses once, 80 cycles after the synchronized falling edge; `o_data` = 0xA5; no error pulses.
- Even parity, 0x37 with parity bit 1 → valid with `o_data` = 0x37. Repeat with parity bit 0 → `o_parity_error` pulses; `o_data` unchanged; no valid pulse.
- 0x00 sent with the stop bit held low → `o_stop_error` pulses once at frame end; no valid pulse. The next good frame 0x5A is then received correctly.
- 3-cycle low glitch on an idle line → FSM returns to IDLE after the start decision; no pulses; `o_busy` high for only 8 cycles.
- Single-cycle inverted spike at the mid-bit sample of data bit 3 in 0xFF → majority rejects it; `o_data` = 0xFF valid.
- `i_rst` asserted during bit 4 → all outputs 0 on the next cycle. The frame then sent, 0x81, is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, parity encodings and the
// 2-of-3 majority helper used by the RX sampler.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// Host-facing signals of the UART receiver; the master side drives the line
// and parity configuration, the slave side (the receiver) returns frame results.
interface uart_rx_deserializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  i_rx_in;
    logic                  i_parity_enable;
    logic                  i_parity_type;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_data_valid;
    logic                  o_parity_error;
    logic                  o_stop_error;
    logic                  o_busy;

    modport master (
        output i_rx_in,
        output i_parity_enable,
        output i_parity_type,
        input  o_data,
        input  o_data_valid,
        input  o_parity_error,
        input  o_stop_error,
        input  o_busy
    );

    modport slave (
        input  i_rx_in,
        input  i_parity_enable,
        input  i_parity_type,
        output o_data,
        output o_data_valid,
        output o_parity_error,
        output o_stop_error,
        output o_busy
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Line synchronizer plus mid-bit 3-sample majority voter; the voted bit is
// latched after the third sample and held until the next bit's vote.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 8,
    parameter int EDGE_W     = $clog2(OVERSAMPLE)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx_in,
    input  logic [EDGE_W-1:0] edge_cnt,
    output logic              rx_sync,
    output logic              rx_bit
);

    localparam logic [EDGE_W-1:0] SAMPLE0 = EDGE_W'(OVERSAMPLE / 2 - 1);
    localparam logic [EDGE_W-1:0] SAMPLE1 = EDGE_W'(OVERSAMPLE / 2);
    localparam logic [EDGE_W-1:0] SAMPLE2 = EDGE_W'(OVERSAMPLE / 2 + 1);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic samp0_q, samp0_d;
    logic samp1_q, samp1_d;
    logic vote_q,  vote_d;

    always_comb begin
        sync1_d = i_rx_in;
        sync2_d = sync1_q;
        samp0_d = samp0_q;
        samp1_d = samp1_q;
        vote_d  = vote_q;
        if (edge_cnt == SAMPLE0) samp0_d = sync2_q;
        if (edge_cnt == SAMPLE1) samp1_d = sync2_q;
        if (edge_cnt == SAMPLE2) vote_d  = majority3(samp0_q, samp1_q, sync2_q);
    end

    // Everything resets to the idle-line level so no false start follows reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            samp0_q <= 1'b1;
            samp1_q <= 1'b1;
            vote_q  <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            samp0_q <= samp0_d;
            samp1_q <= samp1_d;
            vote_q  <= vote_d;
        end
    end

    assign rx_sync = sync2_q;
    assign rx_bit  = vote_q;

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: frame FSM, bit/edge counters, LSB-first shift
// register, parity and stop checks, registered one-cycle frame-end pulses.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    uart_rx_deserializer_if.slave rx_if
);

    localparam int EDGE_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_WIDTH);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    rx_state_e             state_q, state_d;
    logic [EDGE_W-1:0]     edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_type_q, par_type_d;
    logic                  par_err_q, par_err_d;
    logic                  data_valid_q, data_valid_d;
    logic                  parity_error_q, parity_error_d;
    logic                  stop_error_q, stop_error_d;

    logic rx_sync;
    logic rx_bit;
    logic decide;

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE),
        .EDGE_W     (EDGE_W)
    ) u_sampler (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_rx_in  (rx_if.i_rx_in),
        .edge_cnt (edge_cnt_q),
        .rx_sync  (rx_sync),
        .rx_bit   (rx_bit)
    );

    assign decide = (edge_cnt_q == EDGE_LAST);

    always_comb begin
        state_d        = state_q;
        edge_cnt_d     = edge_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        data_d         = data_q;
        par_en_d       = par_en_q;
        par_type_d     = par_type_q;
        par_err_d      = par_err_q;
        data_valid_d   = 1'b0;
        parity_error_d = 1'b0;
        stop_error_d   = 1'b0;

        if (state_q != RX_IDLE) begin
            edge_cnt_d = decide ? '0 : edge_cnt_q + EDGE_W'(1);
        end

        unique case (state_q)
            RX_IDLE: begin
                // The detection cycle is edge 0 of the start bit, so START begins at edge 1.
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                if (!rx_sync) begin
                    state_d    = RX_START;
                    edge_cnt_d = EDGE_W'(1);
                    par_en_d   = rx_if.i_parity_enable;
                    par_type_d = rx_if.i_parity_type;
                    par_err_d  = 1'b0;
                end
            end
            RX_START: begin
                if (decide) state_d = rx_bit ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (decide) begin
                    shift_d = {rx_bit, shift_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? RX_PARITY : RX_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            RX_PARITY: begin
                if (decide) begin
                    par_err_d = rx_bit != ((^shift_q) ^ par_type_q);
                    state_d   = RX_STOP;
                end
            end
            RX_STOP: begin
                if (decide) begin
                    state_d        = RX_IDLE;
                    stop_error_d   = !rx_bit;
                    parity_error_d = par_err_q;
                    if (rx_bit && !par_err_q) begin
                        data_d       = shift_q;
                        data_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= RX_IDLE;
            edge_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            data_q         <= '0;
            par_en_q       <= 1'b0;
            par_type_q     <= PARITY_EVEN;
            par_err_q      <= 1'b0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            edge_cnt_q     <= edge_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            data_q         <= data_d;
            par_en_q       <= par_en_d;
            par_type_q     <= par_type_d;
            par_err_q      <= par_err_d;
            data_valid_q   <= data_valid_d;
            parity_error_q <= parity_error_d;
            stop_error_q   <= stop_error_d;
        end
    end

    // Busy covers the detection cycle itself, before the FSM has left IDLE.
    assign rx_if.o_busy         = (state_q != RX_IDLE) || !rx_sync;
    assign rx_if.o_data         = data_q;
    assign rx_if.o_data_valid   = data_valid_q;
    assign rx_if.o_parity_error = parity_error_q;
    assign rx_if.o_stop_error   = stop_error_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for the UART receiver: drives framed bytes on the raw line
// and checks pulses, timing and received words against hand-derived values.
module tb_uart_rx_deserializer;
    import uart_pkg::*;

    localparam int DW = 8;
    localparam int OS = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_rx_deserializer_if #(.DATA_WIDTH(DW)) rxIf ();

    uart_rx_deserializer #(
        .DATA_WIDTH (DW),
        .OVERSAMPLE (OS)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .rx_if (rxIf)
    );

    int cyc = 0;
    int checkCount = 0;
    int passCount = 0;
    int validCount, perrCount, serrCount, busyCount, overlapCount;
    int validCycle, fallCycle;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rxIf.o_data_valid) begin
            validCount = validCount + 1;
            validCycle = cyc;
        end
        if (rxIf.o_parity_error) perrCount = perrCount + 1;
        if (rxIf.o_stop_error) serrCount = serrCount + 1;
        if (rxIf.o_busy) busyCount = busyCount + 1;
        if (rxIf.o_data_valid && (rxIf.o_parity_error || rxIf.o_stop_error))
            overlapCount = overlapCount + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount = checkCount + 1;
        if (observed !== expected)
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        else
            passCount = passCount + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clearCounts();
        validCount = 0;
        perrCount = 0;
        serrCount = 0;
        busyCount = 0;
        overlapCount = 0;
        validCycle = -1;
    endtask

    task automatic driveBit(input logic v, input int spikeAt);
        for (int k = 0; k < OS; k++) begin
            rxIf.i_rx_in = (k == spikeAt) ? ~v : v;
            @(posedge clk);
            #1;
        end
    endtask

    // Sends one frame; parity inputs are flipped after the start bit to show they are latched.
    task automatic applyStimulus(input logic [DW-1:0] data, input logic parEn,
                                 input logic parType, input logic parBit,
                                 input logic stopBit, input int spikeBit);
        clearCounts();
        rxIf.i_parity_enable = parEn;
        rxIf.i_parity_type = parType;
        fallCycle = cyc;
        driveBit(1'b0, -1);
        rxIf.i_parity_enable = ~parEn;
        rxIf.i_parity_type = ~parType;
        for (int i = 0; i < DW; i++)
            driveBit(data[i], (i == spikeBit) ? OS / 2 : -1);
        if (parEn) driveBit(parBit, -1);
        driveBit(stopBit, -1);
        rxIf.i_rx_in = 1'b1;
        rxIf.i_parity_enable = parEn;
        rxIf.i_parity_type = parType;
        idle(6);
    endtask

    initial begin
        logic [7:0] partial;
        rst = 1'b1;
        rxIf.i_rx_in = 1'b1;
        rxIf.i_parity_enable = 1'b0;
        rxIf.i_parity_type = PARITY_EVEN;
        clearCounts();
        idle(3);
        rst = 1'b0;
        checkOutput("reset_data", 32'(rxIf.o_data), 32'h0);
        checkOutput("reset_valid", 32'(rxIf.o_data_valid), 32'h0);
        checkOutput("reset_perr", 32'(rxIf.o_parity_error), 32'h0);
        checkOutput("reset_serr", 32'(rxIf.o_stop_error), 32'h0);
        checkOutput("reset_busy", 32'(rxIf.o_busy), 32'h0);
        idle(4);

        applyStimulus(8'hA5, 1'b0, PARITY_EVEN, 1'b0, 1'b1, -1);
        checkOutput("a5_valid_count", 32'(validCount), 32'd1);
        checkOutput("a5_latency", 32'(validCycle - fallCycle), 32'd82);
        checkOutput("a5_data", 32'(rxIf.o_data), 32'hA5);
        checkOutput("a5_perr_count", 32'(perrCount), 32'd0);
        checkOutput("a5_serr_count", 32'(serrCount), 32'd0);
        checkOutput("a5_busy_cycles", 32'(busyCount), 32'd80);

        applyStimulus(8'h37, 1'b1, PARITY_EVEN, 1'b1, 1'b1, -1);
        checkOutput("p37_ok_valid", 32'(validCount), 32'd1);
        checkOutput("p37_ok_data", 32'(rxIf.o_data), 32'h37);
        checkOutput("p37_ok_perr", 32'(perrCount), 32'd0);
        checkOutput("p37_ok_latency", 32'(validCycle - fallCycle), 32'd90);

        applyStimulus(8'h37, 1'b1, PARITY_EVEN, 1'b0, 1'b1, -1);
        checkOutput("p37_bad_perr", 32'(perrCount), 32'd1);
        checkOutput("p37_bad_valid", 32'(validCount), 32'd0);
        checkOutput("p37_bad_serr", 32'(serrCount), 32'd0);
        checkOutput("p37_bad_data", 32'(rxIf.o_data), 32'h37);

        applyStimulus(8'h37, 1'b1, PARITY_ODD, 1'b0, 1'b1, -1);
        checkOutput("p37_odd_valid", 32'(validCount), 32'd1);
        checkOutput("p37_odd_perr", 32'(perrCount), 32'd0);

        applyStimulus(8'h00, 1'b0, PARITY_EVEN, 1'b0, 1'b0, -1);
        checkOutput("stop_err_count", 32'(serrCount), 32'd1);
        checkOutput("stop_err_valid", 32'(validCount), 32'd0);
        checkOutput("stop_err_data", 32'(rxIf.o_data), 32'h37);
        checkOutput("stop_err_busy", 32'(busyCount), 32'd80);

        applyStimulus(8'h5A, 1'b0, PARITY_EVEN, 1'b0, 1'b1, -1);
        checkOutput("after_stop_valid", 32'(validCount), 32'd1);
        checkOutput("after_stop_data", 32'(rxIf.o_data), 32'h5A);

        clearCounts();
        rxIf.i_rx_in = 1'b0;
        idle(3);
        rxIf.i_rx_in = 1'b1;
        idle(16);
        checkOutput("glitch_busy_cycles", 32'(busyCount), 32'd8);
        checkOutput("glitch_valid", 32'(validCount), 32'd0);
        checkOutput("glitch_errors", 32'(perrCount + serrCount), 32'd0);
        checkOutput("glitch_data", 32'(rxIf.o_data), 32'h5A);

        applyStimulus(8'hFF, 1'b0, PARITY_EVEN, 1'b0, 1'b1, 3);
        checkOutput("spike_valid", 32'(validCount), 32'd1);
        checkOutput("spike_data", 32'(rxIf.o_data), 32'hFF);

        clearCounts();
        partial = 8'h3C;
        driveBit(1'b0, -1);
        for (int i = 0; i < 4; i++) driveBit(partial[i], -1);
        rxIf.i_rx_in = partial[4];
        idle(3);
        rst = 1'b1;
        rxIf.i_rx_in = 1'b1;
        idle(1);
        rst = 1'b0;
        checkOutput("midrst_data", 32'(rxIf.o_data), 32'h0);
        checkOutput("midrst_valid", 32'(rxIf.o_data_valid), 32'h0);
        checkOutput("midrst_perr", 32'(rxIf.o_parity_error), 32'h0);
        checkOutput("midrst_serr", 32'(rxIf.o_stop_error), 32'h0);
        checkOutput("midrst_busy", 32'(rxIf.o_busy), 32'h0);
        idle(4);

        applyStimulus(8'h81, 1'b0, PARITY_EVEN, 1'b0, 1'b1, -1);
        checkOutput("post_rst_valid", 32'(validCount), 32'd1);
        checkOutput("post_rst_data", 32'(rxIf.o_data), 32'h81);

        checkOutput("no_valid_error_overlap", 32'(overlapCount), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
